// File: rtl/psum_pass_ctrl_if.sv
// psum_pass_ctrl_if: BN-vector handshake, psum FIFO and ReLU routing strobes.
// master = sequencer side, slave = datapath / FIFO side.
interface psum_pass_ctrl_if;
  logic bn_v;
  logic bn_rdy;
  logic fifo_empty;
  logic fifo_rd;
  logic psum_v;
  logic fifo_wr;
  logic relu_v;

  modport master (
    input  bn_v, fifo_empty, psum_v,
    output bn_rdy, fifo_rd, fifo_wr, relu_v
  );

  modport slave (
    output bn_v, fifo_empty, psum_v,
    input  bn_rdy, fifo_rd, fifo_wr, relu_v
  );
endinterface

// File: rtl/psum_pass_ctrl.sv
// psum_pass_ctrl: pass/vector sequencer for the 64-channel partial-sum
// accumulator. Meters BN vectors into the adder, pops history psums on
// non-first passes, and routes finished psums to the FIFO or to ReLU.
// Optional: define PSUM_CTRL_PERF_EN to add the stall_cycles counter port.
module psum_pass_ctrl #(
  parameter int VEC_PER_PASS = 3750,
  parameter int NUM_PASS     = 4,
  parameter int SLICE_BEATS  = 8,
  localparam int PW = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1,
  localparam int BW = (SLICE_BEATS > 1) ? $clog2(SLICE_BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  psum_pass_ctrl_if.master     bus,
  output logic                 first_pass,
  output logic [PW-1:0]        pass_idx,
  output logic [11:0]          vec_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef PSUM_CTRL_PERF_EN
  , output logic [31:0]        stall_cycles
`endif
);

  localparam logic [11:0]   VEC_LAST  = 12'(VEC_PER_PASS - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASS - 1);
  localparam logic [BW-1:0] BEAT_LOAD = BW'(SLICE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_n;

  logic [BW-1:0] beat_cnt;
  logic [11:0]   out_cnt;
  logic [PW-1:0] out_pass;
  logic          out_fin;
  logic [15:0]   outstanding;
  logic          rdy, accept, psum_ok, in_last, out_last, launch;

  // Input and output sides are tracked independently; they only meet in
  // the outstanding count and the FLUSH exit condition.
  assign launch   = (state == IDLE) && start;
  assign rdy      = (state == RUN) && (beat_cnt == '0) && (first_pass || !bus.fifo_empty);
  assign accept   = bus.bn_v && rdy;
  assign in_last  = accept && (vec_idx == VEC_LAST) && (pass_idx == PASS_LAST);
  assign psum_ok  = bus.psum_v && ((state == RUN) || (state == FLUSH));
  assign out_last = psum_ok && (out_cnt == VEC_LAST) && (out_pass == PASS_LAST);

  assign bus.bn_rdy  = rdy;
  assign bus.fifo_rd = accept && !first_pass;
  assign bus.fifo_wr = psum_ok && (out_pass != PASS_LAST);
  assign bus.relu_v  = psum_ok && (out_pass == PASS_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state and state-decoded status outputs.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:  if (start) state_n = RUN;
      RUN: begin
        busy = 1'b1;
        if (in_last) state_n = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (out_last || out_fin) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Input side: slice-beat metering, vector/pass position, first-pass flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt   <= '0;
      vec_idx    <= '0;
      pass_idx   <= '0;
      first_pass <= 1'b1;
    end else if (launch) begin
      beat_cnt   <= '0;
      vec_idx    <= '0;
      pass_idx   <= '0;
      first_pass <= 1'b1;
    end else begin
      if (beat_cnt != '0) beat_cnt <= beat_cnt - BW'(1);
      if (accept) begin
        beat_cnt <= BEAT_LOAD;
        if (vec_idx == VEC_LAST) begin
          vec_idx    <= '0;
          first_pass <= 1'b0;
          // The last pass holds its index until the layer ends.
          if (pass_idx != PASS_LAST) pass_idx <= pass_idx + PW'(1);
        end else begin
          vec_idx <= vec_idx + 12'd1;
        end
      end
    end
  end

  // Output side: position of finished psums, and a flag once the last one lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt  <= '0;
      out_pass <= '0;
      out_fin  <= 1'b0;
    end else if (launch) begin
      out_cnt  <= '0;
      out_pass <= '0;
      out_fin  <= 1'b0;
    end else if (psum_ok) begin
      if (out_last) out_fin <= 1'b1;
      if (out_cnt == VEC_LAST) begin
        out_cnt <= '0;
        if (out_pass != PASS_LAST) out_pass <= out_pass + PW'(1);
      end else begin
        out_cnt <= out_cnt + 12'd1;
      end
    end
  end

  // Vectors in flight through the adder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
    end else if (launch) begin
      outstanding <= '0;
    end else begin
      case ({accept, psum_ok})
        2'b10:   outstanding <= outstanding + 16'd1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 16'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky protocol error; a fresh violation wins over the clear on start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err <= 1'b0;
    else if (bus.psum_v && ((state == IDLE) || (outstanding == '0)))
      err <= 1'b1;
    else if (launch)
      err <= 1'b0;
  end

`ifdef PSUM_CTRL_PERF_EN
  // Cycles in RUN where upstream offered a vector but it was held off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles <= '0;
    else if (launch)
      stall_cycles <= '0;
    else if ((state == RUN) && bus.bn_v && !rdy && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_psum_pass_ctrl.sv
// tb_psum_pass_ctrl: directed + randomized bench for psum_pass_ctrl with a
// count-based reference model (vectors accepted, psums returned, gap since
// last accept) compared against the DUT every cycle.
module tb_psum_pass_ctrl;
  localparam int VPP = 4, NP = 2, SB = 8, TOT = VPP * NP;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, start2 = 1'b0;
  always #5 clk = ~clk;

  psum_pass_ctrl_if bus();
  psum_pass_ctrl_if bus2();

  logic       first_pass, busy, done, err;
  logic [0:0] pass_idx;
  logic [11:0] vec_idx;
  logic       fp2, busy2, done2, err2;
  logic [1:0] pidx2;
  logic [11:0] vidx2;
`ifdef PSUM_CTRL_PERF_EN
  logic [31:0] stall1, stall2;
`endif

  psum_pass_ctrl #(.VEC_PER_PASS(VPP), .NUM_PASS(NP), .SLICE_BEATS(SB)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .first_pass(first_pass), .pass_idx(pass_idx), .vec_idx(vec_idx),
    .busy(busy), .done(done), .err(err)
`ifdef PSUM_CTRL_PERF_EN
    , .stall_cycles(stall1)
`endif
  );

  // Default vector/pass counts; short slices keep the full layer run brief.
  psum_pass_ctrl #(.VEC_PER_PASS(3750), .NUM_PASS(4), .SLICE_BEATS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(bus2),
    .first_pass(fp2), .pass_idx(pidx2), .vec_idx(vidx2),
    .busy(busy2), .done(done2), .err(err2)
`ifdef PSUM_CTRL_PERF_EN
    , .stall_cycles(stall2)
`endif
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  cyc = 0;
  bit  m_active = 0, m_done = 0, m_err = 0;
  int  m_n = 0, m_p = 0, m_gap = SB;
  longint m_stall = 0;
  bit  acc_s, psum_s, start_s, stall_s;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 0; m_done <= 0; m_err <= 0;
      m_n <= 0; m_p <= 0; m_gap <= SB; m_stall <= 0;
    end else begin
      m_done <= 0;
      if (!m_active && !m_done && start_s) begin
        m_active <= 1; m_n <= 0; m_p <= 0; m_gap <= SB; m_err <= psum_s; m_stall <= 0;
      end else begin
        if (psum_s && (!m_active || m_n == m_p)) m_err <= 1;
        m_gap <= acc_s ? 1 : ((m_gap < SB) ? m_gap + 1 : SB);
        if (stall_s) m_stall <= m_stall + 1;
        if (m_active) begin
          if (acc_s) m_n <= m_n + 1;
          if (psum_s) begin
            m_p <= m_p + 1;
            if (m_p + 1 == TOT) begin m_active <= 0; m_done <= 1; end
          end
        end
      end
    end
  end

  // ---------------- compare + monitor (negedge) ----------------
  int psum_mode = 0;          // 0 none, 1 fixed 10-cycle latency, 2 random
  int due[$];
  int acc_cyc[$];
  bit acc_rd[$];
  int n_wr = 0, n_relu = 0, n_done = 0, done_cyc = -1, fp_fall = -1;
  bit fp_prev = 1;

  always @(negedge clk) begin : compare
    bit rdy_e, first_e, run_e;
    int pass_e;
    first_e = (m_n < VPP);
    run_e   = m_active && (m_n < TOT);
    rdy_e   = run_e && (m_gap >= SB) && (first_e || !bus.fifo_empty);
    pass_e  = (m_n / VPP < NP - 1) ? m_n / VPP : NP - 1;
    chk("bn_rdy", bus.bn_rdy, rdy_e);
    chk("fifo_rd", bus.fifo_rd, bus.bn_v && rdy_e && !first_e);
    chk("fifo_wr", bus.fifo_wr, m_active && bus.psum_v && (m_p / VPP != NP - 1));
    chk("relu_v", bus.relu_v, m_active && bus.psum_v && (m_p / VPP == NP - 1));
    chk("first_pass", first_pass, first_e);
    chk("pass_idx", pass_idx, pass_e);
    chk("vec_idx", vec_idx, m_n % VPP);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("err", err, m_err);
`ifdef PSUM_CTRL_PERF_EN
    chk("stall_cycles", stall1, m_stall);
`endif
    acc_s   <= bus.bn_v && rdy_e;
    psum_s  <= bus.psum_v;
    start_s <= start;
    stall_s <= run_e && bus.bn_v && !rdy_e;
    if (bus.bn_v && bus.bn_rdy) begin
      acc_cyc.push_back(cyc);
      acc_rd.push_back(bus.fifo_rd);
      if (psum_mode == 1) due.push_back(cyc + 10);
    end
    if (bus.fifo_wr) n_wr <= n_wr + 1;
    if (bus.relu_v)  n_relu <= n_relu + 1;
    if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
    if (fp_prev && !first_pass) fp_fall <= cyc;
    fp_prev <= first_pass;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
    start = 0;
    bus.psum_v = 0;
    if (psum_mode == 1 && due.size() > 0 && due[0] == cyc) begin
      bus.psum_v = 1;
      void'(due.pop_front());
    end else if (psum_mode == 2) begin
      bus.psum_v = m_active && (m_n > m_p) && ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic clear_mon();
    acc_cyc.delete(); acc_rd.delete(); due.delete();
    n_wr = 0; n_relu = 0; n_done = 0; done_cyc = -1; fp_fall = -1;
  endtask

  task automatic wait_done(input string nm, input int limit);
    int nd0 = n_done;
    for (int i = 0; i < limit && n_done == nd0; i++) step();
    chk(nm, n_done - nd0, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s, a0, acc2, wr2, relu2, dn2;
    bit a;
    bus.bn_v = 0; bus.fifo_empty = 0; bus.psum_v = 0;
    bus2.bn_v = 0; bus2.fifo_empty = 0; bus2.psum_v = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_first_pass", first_pass, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bn_rdy", bus.bn_rdy, 0);
    chk("rst_err", err, 0);
    rst = 1;

    // T1: bn_v held high, FIFO never empty, psum 10 cycles after accept.
    clear_mon();
    bus.bn_v = 1; bus.fifo_empty = 0; psum_mode = 1;
    step(); start = 1; s = cyc;
    wait_done("t1_done_seen", 300);
    repeat (3) step();
    chk("t1_accepts", acc_cyc.size(), 8);
    if (acc_cyc.size() == 8) begin
      a0 = acc_cyc[0];
      chk("t1_first_accept_lat", a0 - s, 1);
      for (int i = 0; i < 8; i++) begin
        chk("t1_accept_spacing", acc_cyc[i] - a0, 8 * i);
        chk("t1_fifo_rd", acc_rd[i], (i >= 4) ? 1 : 0);
      end
      chk("t1_first_pass_fall", fp_fall - a0, 25);
      chk("t1_done_cycle", done_cyc - a0, 67);
    end
    chk("t1_fifo_wr_count", n_wr, 4);
    chk("t1_relu_count", n_relu, 4);
    chk("t1_done_count", n_done, 1);

    // T2: FIFO empty for 20 cycles at the start of pass 1.
    clear_mon();
    step(); start = 1;
    for (int i = 0; i < 200 && acc_cyc.size() < 5; i++) step();
    bus.fifo_empty = 1;
    repeat (20) step();
    chk("t2_stall_accepts", acc_cyc.size(), 5);
    chk("t2_stall_vec", vec_idx, 1);
    chk("t2_stall_pass", pass_idx, 1);
    chk("t2_stall_rdy", bus.bn_rdy, 0);
    step(); bus.fifo_empty = 0;
    @(negedge clk);
    chk("t2_release_rdy", bus.bn_rdy, 1);
    chk("t2_release_fifo_rd", bus.fifo_rd, 1);
    wait_done("t2_done_seen", 300);
    chk("t2_fifo_wr_count", n_wr, 4);
    chk("t2_relu_count", n_relu, 4);

    // T3: psum_v while idle raises sticky err; start clears it.
    psum_mode = 0;
    step(); bus.psum_v = 1;
    step();
    chk("t3_err_set", err, 1);
    repeat (5) step();
    chk("t3_err_hold", err, 1);
    clear_mon(); psum_mode = 1;
    start = 1;
    step();
    chk("t3_err_clear", err, 0);
    chk("t3_busy", busy, 1);

    // T4: reset mid pass 1 at vec_idx 2, then restart.
    for (int i = 0; i < 200 && acc_cyc.size() < 6; i++) step();
    chk("t4_pre_vec", vec_idx, 2);
    chk("t4_pre_pass", pass_idx, 1);
    psum_mode = 0; due.delete();
    bus.psum_v = 1;
    #1 rst = 0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_first_pass", first_pass, 1);
    chk("t4_rst_vec", vec_idx, 0);
    chk("t4_rst_pass", pass_idx, 0);
    chk("t4_rst_bn_rdy", bus.bn_rdy, 0);
    chk("t4_rst_fifo_wr", bus.fifo_wr, 0);
    chk("t4_rst_relu", bus.relu_v, 0);
    chk("t4_rst_err", err, 0);
    bus.psum_v = 0;
    repeat (2) step();
    chk("t4_no_done", n_done, 0);
    rst = 1;
    clear_mon(); psum_mode = 1;
    step(); start = 1;
    step();
    chk("t4_restart_pass", pass_idx, 0);
    chk("t4_restart_vec", vec_idx, 0);
    wait_done("t4_done_seen", 300);

    // T5: randomized layers.
    psum_mode = 2;
    for (int l = 0; l < 6; l++) begin
      int nd0;
      nd0 = n_done;
      step(); start = 1;
      for (int i = 0; i < 3000 && n_done == nd0; i++) begin
        step();
        bus.bn_v = ($urandom_range(0, 2) != 0);
        bus.fifo_empty = ($urandom_range(0, 3) == 0);
      end
      chk("t5_layer_done", n_done - nd0, 1);
    end
    psum_mode = 0; bus.bn_v = 0;
    repeat (3) step();

    // T6: default vector/pass counts, 15000 accepts.
    acc2 = 0; wr2 = 0; relu2 = 0; dn2 = 0;
    bus2.bn_v = 1; bus2.fifo_empty = 0;
    @(posedge clk); #1 start2 = 1;
    @(posedge clk); #1 start2 = 0;
    for (int i = 0; i < 40000 && dn2 == 0; i++) begin
      @(negedge clk);
      a = bus2.bn_v && bus2.bn_rdy;
      acc2 += int'(a); wr2 += int'(bus2.fifo_wr); relu2 += int'(bus2.relu_v); dn2 += int'(done2);
      @(posedge clk); #1 bus2.psum_v = a;
    end
    repeat (4) begin
      @(negedge clk);
      dn2 += int'(done2);
    end
    chk("t6_accepts", acc2, 15000);
    chk("t6_fifo_wr", wr2, 11250);
    chk("t6_relu_v", relu2, 3750);
    chk("t6_done", dn2, 1);
    chk("t6_err", err2, 0);
    chk("t6_busy_after", busy2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
